spi_slave_shift: RTL and testbench
==================================

Name: spi_slave_shift

Overview:
SPI responder (slave) shift engine; the far-end counterpart to our SPI master serializer.
- Oversamples SCLK/CS_N/MOSI in the clk domain.
- Receives LSB-first frames of 8/16/24/32 bits and returns a pre-loaded word on MISO in the same frame.
- SPI mode 0: sample on rising SCLK, change on falling SCLK.
- Sits between the pad-level SPI pins and the peripheral register block / testbench model of the slave device.

Parameters:
- DATA_WIDTH, 32, maximum frame and parallel word width.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n, mosi (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sclk  input  1  SPI serial clock from master (asynchronous)
- cs_n  input  1  SPI chip select, active low (asynchronous)
- mosi  input  1  serial data from master
- miso  output  1  serial data to master
- miso_oe  output  1  MISO output enable (1 while frame active)
- spi_data_len  input  2  frame length: 00=8, 01=16, 10=24, 11=32 bits
- tx_data  input  DATA_WIDTH  word to transmit in the next frame
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  one-entry TX buffer empty
- rx_data  output  DATA_WIDTH  last received word, right-aligned
- rx_valid  output  1  one-cycle pulse: rx_data updated
- underrun  output  1  one-cycle pulse: frame started with empty TX buffer
- frame_err  output  1  one-cycle pulse: cs_n deasserted before N bits

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, frame_err=0. Internal state: state=IDLE, bit counter=0, shift registers=0, sync flops to idle levels (sclk=0, cs_n=1, mosi=0).
- Sync and edge detect:
  - SYNC_STAGES flops per input, plus one history flop for edge detection.
  - Each detected edge acts exactly once.
  - Pin-to-action latency is SYNC_STAGES+1 clk edges.
  - Timing constraints on the master: SCLK high and low phases ≥ SYNC_STAGES+2 clk; cs_n fall to first SCLK rise ≥ SYNC_STAGES+3 clk.
- TX buffer (one entry):
  - Write when tx_valid && tx_ready; tx_ready goes 0 the next cycle.
  - Consumed at frame start; tx_ready returns to 1 the cycle after the cs_n fall is detected.
  - A write in the same cycle as the consume is not accepted; tx_ready=0 in that cycle.
- State IDLE:
  - miso=0, miso_oe=0.
  - Synced cs_n falling edge → ACTIVE. In that same action cycle:
    - Latch N from spi_data_len. Changes mid-frame are ignored.
    - Load tx shift register from the buffer. If the buffer is empty, load zeros and pulse underrun.
    - Clear bit counter and rx shift register.
    - miso<=tx bit0, miso_oe<=1.
- State ACTIVE:
  - Synced SCLK rising: rx_shift[bit_cnt]<=mosi_sync, bit_cnt+=1.
  - Synced SCLK falling with bit_cnt<N: miso<=tx_shift[bit_cnt].
  - When the rising edge that completes bit N is processed: next cycle rx_data<={zeros, received N bits} (bit k received → rx_data[k]; bits ≥N are 0), rx_valid=1 for exactly one cycle, state→DONE.
  - Synced cs_n rising before N bits: abort. rx_data unchanged, no rx_valid, frame_err pulse 1 cycle, miso=0, miso_oe=0, state→IDLE.
- State DONE:
  - miso holds last driven bit, miso_oe=1.
  - Further SCLK edges are ignored (no wrap, counter saturates at N).
  - Synced cs_n rising → IDLE, miso=0, miso_oe=0, no error.
- Simultaneous synced cs_n rise and the Nth SCLK rise in the same cycle: the frame completes (rx_valid), no frame_err.
- rst asserted mid-frame: immediate return to reset values. The TX buffer is emptied (tx_ready=1). No pulses are generated.
- A cs_n low at reset release is not a frame. A frame starts only on a detected falling edge.

Test Plan:
- tx_data=0x000000A5 written, spi_data_len=00, master sends 8 bits of 0x3C LSB-first → MISO bits 1,0,1,0,0,1,0,1; rx_data=0x0000003C; rx_valid single pulse ≤4 clk after 8th SCLK rise; tx_ready back to 1.
- spi_data_len=11, tx_data=0xDEADBEEF, master sends 0x12345678 → MISO returns 0xDEADBEEF LSB-first; rx_data=0x12345678; underrun=0, frame_err=0.
- spi_data_len=01, master sends 0xFFFFFFFF pattern for 20 SCLKs → rx_data=0x0000FFFF; single rx_valid; extra 4 SCLKs ignored; MISO stable after bit 16.
- No tx_valid before frame, 8-bit frame → underrun pulse at cs_n fall; MISO all 0; rx_data captured normally.
- 32-bit frame, cs_n raised after 5 SCLKs → frame_err pulse; rx_data keeps the prior value; no rx_valid. Next full 8-bit frame 0x81 → rx_data=0x00000081.
- rst pulsed after 10 of 16 bits → all outputs return to reset values, tx_ready=1. The following frame after a fresh cs_n fall completes correctly.

Source files
------------

// File: rtl/spi_slave_shift_if.sv
// Interface bundling the SPI pins and the parallel TX/RX side of spi_slave_shift.
`timescale 1ns / 1ps
interface spi_slave_shift_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [1:0]            spi_data_len;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  underrun;
  logic                  frame_err;

  modport slave (
    input  sclk, cs_n, mosi, spi_data_len, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, spi_data_len, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
  );
endinterface

// File: rtl/spi_slave_shift.sv
// SPI mode-0 responder: oversampled pins, LSB-first 8/16/24/32-bit frames,
// one-entry TX buffer returned on MISO while the master's word is captured.
`timescale 1ns / 1ps
module spi_slave_shift #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  spi_slave_shift_if.slave bus
);
  localparam int unsigned CntW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IdxW  = $clog2(DATA_WIDTH);
  localparam int unsigned WarmW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic [WarmW-1:0]       warm_q;
  logic                   sclk_s, cs_s, mosi_s, warm;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [1:0]            len_q;
  logic [CntW-1:0]       bit_cnt_q, n_bits;
  logic [IdxW-1:0]       bit_idx;
  logic [DATA_WIDTH-1:0] tx_shift_q, rx_shift_q, tx_buf_q, rx_data_q;
  logic [DATA_WIDTH-1:0] rx_merged, tx_first;
  logic                  tx_full_q, miso_q, miso_oe_q;
  logic                  rx_valid_q, underrun_q, frame_err_q;
  logic                  last_bit, consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      warm_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
      if (!warm) warm_q <= warm_q + WarmW'(1);
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  // cs edges are ignored until the synchronizer holds real pin samples, so a
  // cs_n already low at reset release is not mistaken for a frame start.
  assign warm      = (warm_q == WarmW'(SYNC_STAGES + 1));
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = warm & cs_s & ~cs_hist_q;
  assign cs_fall   = warm & ~cs_s & cs_hist_q;

  always_comb begin
    n_bits    = CntW'((32'(len_q) + 32'd1) * 32'd8);
    bit_idx   = bit_cnt_q[IdxW-1:0];
    last_bit  = sclk_rise && (bit_cnt_q == n_bits - CntW'(1));
    consume   = (state_q == StIdle) && cs_fall;
    tx_first  = tx_full_q ? tx_buf_q : '0;
    rx_merged = rx_shift_q;
    rx_merged[bit_idx] = mosi_s;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StActive;
      // A cs_n rise landing with the final bit still completes the frame.
      StActive: begin
        if (last_bit)     state_d = cs_rise ? StIdle : StDone;
        else if (cs_rise) state_d = StIdle;
      end
      StDone:   if (cs_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= 2'b00;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (consume) begin
        tx_full_q <= 1'b0;
      end else if (bus.tx_valid && bus.tx_ready) begin
        tx_full_q <= 1'b1;
        tx_buf_q  <= bus.tx_data;
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            len_q      <= bus.spi_data_len;
            tx_shift_q <= tx_first;
            underrun_q <= ~tx_full_q;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_q     <= tx_first[0];
            miso_oe_q  <= 1'b1;
          end
        end
        StActive: begin
          if (last_bit) begin
            rx_shift_q[bit_idx] <= mosi_s;
            bit_cnt_q  <= bit_cnt_q + CntW'(1);
            rx_data_q  <= rx_merged;
            rx_valid_q <= 1'b1;
            if (cs_rise) begin
              miso_q    <= 1'b0;
              miso_oe_q <= 1'b0;
            end
          end else if (cs_rise) begin
            frame_err_q <= 1'b1;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q[bit_idx] <= mosi_s;
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end else if (sclk_fall) begin
            miso_q <= tx_shift_q[bit_idx];
          end
        end
        StDone: begin
          if (cs_rise) begin
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.tx_ready  = ~tx_full_q & ~consume;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_shift.sv
// Scoreboard bench for spi_slave_shift: a master-side driver pushes expected
// pulses/words, a monitor pops them whenever the DUT raises a pulse.
`timescale 1ns / 1ps
module tb_spi_slave_shift;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_shift_if #(.DATA_WIDTH(DW)) bus ();
  spi_slave_shift #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum int {EvRx = 0, EvErr = 1, EvUnd = 2} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int unsigned nth_rise_cyc = 0;
  bit          buf_full = 1'b0;
  logic [31:0] buf_word = '0;
  logic [31:0] last_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input ev_kind_e kind, input logic [31:0] data);
    ev_t ev;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
    end else begin
      ev = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(ev.kind));
      if (kind == EvRx) chk("rx_data", data, ev.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.underrun)  expect_ev(EvUnd, '0);
      if (bus.frame_err) expect_ev(EvErr, '0);
      if (bus.rx_valid) begin
        expect_ev(EvRx, bus.rx_data);
        chk("rx_latency_le4", 32'(cyc - nth_rise_cyc <= 4), 32'd1);
      end
    end
  end

  task automatic write_tx(input logic [31:0] w);
    chk("tx_ready_before_write", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("tx_ready_after_write", 32'(bus.tx_ready), 32'd0);
    buf_full = 1'b1;
    buf_word = w;
  endtask

  // Reference: frame of n=(len+1)*8 bits; MISO carries tx bits 0..n-1 then
  // holds bit n-1; rx = first n MOSI bits; fewer than n SCLKs is an abort.
  task automatic spi_frame(input logic [1:0] len, input logic [31:0] mo, input int nsclk,
                           input bit end_cs);
    int          n;
    logic [63:0] m64;
    logic [31:0] mask, txw, mi, exp_mi;
    ev_t         ev;
    n    = (int'(len) + 1) * 8;
    m64  = (64'd1 << n) - 64'd1;
    mask = m64[31:0];
    txw  = buf_full ? buf_word : 32'd0;
    if (!buf_full) begin
      ev.kind = EvUnd; ev.data = '0; exp_q.push_back(ev);
    end
    if (nsclk >= n) begin
      ev.kind = EvRx; ev.data = mo & mask; exp_q.push_back(ev);
      last_rx = mo & mask;
    end else if (end_cs) begin
      ev.kind = EvErr; ev.data = '0; exp_q.push_back(ev);
    end
    buf_full = 1'b0;

    bus.spi_data_len = len;
    bus.cs_n = 1'b0;
    clks(8);
    chk("miso_oe_active", 32'(bus.miso_oe), 32'd1);
    chk("tx_ready_after_start", 32'(bus.tx_ready), 32'd1);
    mi = '0;
    exp_mi = '0;
    for (int i = 0; i < nsclk; i++) begin
      bus.mosi = (i < 32) ? mo[i] : 1'b0;
      clks(6);
      if (i < 32) begin
        mi[i]     = bus.miso;
        exp_mi[i] = (i < n) ? txw[i] : txw[n-1];
      end
      bus.sclk = 1'b1;
      if (i == n - 1) nth_rise_cyc = cyc;
      if (i == 0) bus.spi_data_len = ~len;
      clks(6);
      bus.sclk = 1'b0;
    end
    clks(6);
    chk("miso_word", mi, exp_mi);
    if (end_cs) begin
      bus.cs_n = 1'b1;
      clks(8);
      chk("miso_oe_idle", 32'(bus.miso_oe), 32'd0);
      chk("miso_idle", 32'(bus.miso), 32'd0);
      chk("rx_data_after_frame", bus.rx_data, last_rx);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.spi_data_len = 2'b00;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    clks(3);
    chk("rst_miso", 32'(bus.miso), 32'd0);
    chk("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_rx_data", bus.rx_data, 32'd0);
    chk("rst_pulses", {29'd0, bus.rx_valid, bus.underrun, bus.frame_err}, 32'd0);
    rst = 1'b0;
    clks(10);

    write_tx(32'h0000_00A5);
    spi_frame(2'b00, 32'h0000_003C, 8, 1'b1);
    write_tx(32'hDEAD_BEEF);
    spi_frame(2'b11, 32'h1234_5678, 32, 1'b1);
    write_tx($urandom);
    spi_frame(2'b01, 32'hFFFF_FFFF, 20, 1'b1);
    spi_frame(2'b00, 32'h0000_005A, 8, 1'b1);
    write_tx($urandom);
    spi_frame(2'b11, $urandom, 5, 1'b1);
    write_tx($urandom);
    spi_frame(2'b00, 32'h0000_0081, 8, 1'b1);

    // Reset in the middle of a 16-bit frame, cs_n still low at release.
    write_tx($urandom);
    spi_frame(2'b01, $urandom, 10, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_miso", 32'(bus.miso), 32'd0);
    chk("midrst_miso_oe", 32'(bus.miso_oe), 32'd0);
    chk("midrst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("midrst_rx_data", bus.rx_data, 32'd0);
    chk("midrst_pulses", {29'd0, bus.rx_valid, bus.underrun, bus.frame_err}, 32'd0);
    buf_full = 1'b0;
    last_rx  = '0;
    clks(2);
    rst = 1'b0;
    clks(10);
    chk("cs_low_at_release_oe", 32'(bus.miso_oe), 32'd0);
    chk("cs_low_at_release_ready", 32'(bus.tx_ready), 32'd1);
    bus.cs_n = 1'b1;
    clks(10);
    chk("cs_rise_idle_oe", 32'(bus.miso_oe), 32'd0);
    write_tx($urandom);
    spi_frame(2'b01, $urandom, 16, 1'b1);

    for (int k = 0; k < 20; k++) begin
      logic [1:0] len;
      int         n, ns;
      bit         abort;
      len   = 2'($urandom_range(0, 3));
      n     = (int'(len) + 1) * 8;
      abort = ($urandom_range(0, 4) == 0);
      ns    = abort ? int'($urandom_range(1, n - 1)) : n + int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) write_tx($urandom);
      spi_frame(len, $urandom, ns, 1'b1);
    end

    clks(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
